// File: rtl/dma_rd_arbiter_pkg.sv
// dma_rd_arbiter_pkg: FSM state type, source port tags and AXI burst/response codes
// shared by the DMA read arbiter and its grant logic.
package dma_rd_arbiter_pkg;

  localparam logic PORT_RX = 1'b0;
  localparam logic PORT_TX = 1'b1;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dma_rd_arbiter_rr_arb2.sv
// dma_rd_arbiter_rr_arb2: two-requester grant selection. Round robin against last_gnt by
// default; with E1000_ARB_FIXED_PRIO_EN defined, requester 1 (tx) wins every tie.
module dma_rd_arbiter_rr_arb2 (
  input  logic [1:0] eligible,
  input  logic       last_gnt,
  output logic       any_eligible,
  output logic       gnt
);

  assign any_eligible = |eligible;

`ifdef E1000_ARB_FIXED_PRIO_EN
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
  assign gnt = eligible[1];
`else
  // A tie goes to the port that did not win last time.
  assign gnt = (&eligible) ? ~last_gnt : eligible[1];
`endif

endmodule

// File: rtl/dma_rd_arbiter.sv
// dma_rd_arbiter: shares one AXI3 read master between rx (s0) and tx (s1). AR is arbitrated
// and tagged in the ARID MSB; R beats route back by RID MSB. Tie rule: E1000_ARB_FIXED_PRIO_EN.
module dma_rd_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter int LEN_W   = 4,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 3
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ID_W-1:0]   s0_arid,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [LEN_W-1:0]  s0_arlen,
  input  logic [2:0]        s0_arsize,
  input  logic [1:0]        s0_arburst,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  output logic [ID_W-1:0]   s0_rid,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0]        s0_rresp,
  output logic              s0_rlast,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  input  logic [ID_W-1:0]   s1_arid,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [LEN_W-1:0]  s1_arlen,
  input  logic [2:0]        s1_arsize,
  input  logic [1:0]        s1_arburst,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  output logic [ID_W-1:0]   s1_rid,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0]        s1_rresp,
  output logic              s1_rlast,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [ID_W-1:0]   m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [LEN_W-1:0]  m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [ID_W-1:0]   m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready
);
  import dma_rd_arbiter_pkg::*;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  arb_state_t state_reg, state_next;
  logic       gnt_reg, gnt_next;
  logic       last_gnt_reg, last_gnt_next;
  logic       arb_gnt, arb_any;
  logic       ar_fire, r_port;
  logic [1:0] ar_valid_v, ar_ready_v, r_valid_v, r_ready_v, eligible;
  logic       unused_arid_msb;

  assign unused_arid_msb = s0_arid[ID_W-1] ^ s1_arid[ID_W-1];
  assign ar_valid_v = {s1_arvalid, s0_arvalid};
  assign r_ready_v  = {s1_rready, s0_rready};
  assign s0_arready = ar_ready_v[0];
  assign s1_arready = ar_ready_v[1];
  assign s0_rvalid  = r_valid_v[0];
  assign s1_rvalid  = r_valid_v[1];
  assign m_arvalid  = (state_reg == ST_ISSUE);
  assign ar_fire    = m_arvalid && m_arready;
  assign r_port     = m_rid[ID_W-1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             issue, retire;

      assign eligible[gi]   = ar_valid_v[gi] && (cnt_reg < MAX_CNT);
      assign ar_ready_v[gi] = ar_fire && (gnt_reg == 1'(gi));
      assign r_valid_v[gi]  = m_rvalid && (r_port == 1'(gi));
      assign issue          = ar_ready_v[gi];
      assign retire         = r_valid_v[gi] && r_ready_v[gi] && m_rlast;

      // Saturating both ways: a stray rlast cannot underflow, a full port cannot overflow.
      always_comb begin
        cnt_next = cnt_reg;
        if (issue && !retire) begin
          if (cnt_reg != MAX_CNT) cnt_next = cnt_reg + CNT_W'(1);
        end else if (retire && !issue) begin
          if (cnt_reg != '0) cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) cnt_reg <= '0;
        else          cnt_reg <= cnt_next;
      end
    end
  endgenerate

  dma_rd_arbiter_rr_arb2 u_rr_arb2 (
    .eligible     (eligible),
    .last_gnt     (last_gnt_reg),
    .any_eligible (arb_any),
    .gnt          (arb_gnt)
  );

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    last_gnt_next = last_gnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (arb_any) begin
          gnt_next   = arb_gnt;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_arready) begin
          last_gnt_next = gnt_reg;
          state_next    = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg    <= ST_IDLE;
      gnt_reg      <= PORT_RX;
      last_gnt_reg <= PORT_TX;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      last_gnt_reg <= last_gnt_next;
    end
  end

  assign m_arid    = {gnt_reg, gnt_reg ? s1_arid[ID_W-2:0] : s0_arid[ID_W-2:0]};
  assign m_araddr  = gnt_reg ? s1_araddr  : s0_araddr;
  assign m_arlen   = gnt_reg ? s1_arlen   : s0_arlen;
  assign m_arsize  = gnt_reg ? s1_arsize  : s0_arsize;
  assign m_arburst = gnt_reg ? s1_arburst : s0_arburst;

  // R channel is a pure combinational fan-out; the requester sees its own ID space.
  assign s0_rid   = {1'b0, m_rid[ID_W-2:0]};
  assign s1_rid   = {1'b0, m_rid[ID_W-2:0]};
  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;
  assign s0_rresp = m_rresp;
  assign s1_rresp = m_rresp;
  assign s0_rlast = m_rlast;
  assign s1_rlast = m_rlast;
  assign m_rready = r_ready_v[r_port];

endmodule
